// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw lines, frames bytes and maps arrow/enter/escape keys to held levels.
// Optional build macro PS2_PARITY_CHECK_EN enforces odd parity on received frames.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] keyboard_out,
    output logic [7:0] scan_code,
    output logic       frame_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      r_state;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_data_sync;
    logic        r_clk_prev;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_parity;
    logic [TW-1:0] r_to_cnt;
    logic        r_ext;
    logic        r_brk;
    logic [3:0]  r_keys;
    logic [7:0]  r_scan;
    logic        r_valid;
    logic        r_err;

    logic        w_fall;
    logic        w_bit;
    logic        w_timeout;
    logic        w_accept;

    // Synchronizers idle high so releasing reset cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_bit     = r_data_sync[1];
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign w_accept = ^{r_shift, r_parity};
`else
    // Parity is still captured so the frame layout stays identical; it is not enforced.
    assign w_accept = r_parity | 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_keys    <= '0;
            r_scan    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (r_state == IDLE || w_fall || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_timeout) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_err     <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_bit) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_bit && w_accept) begin
                            r_scan  <= r_shift;
                            r_valid <= 1'b1;
                            // Prefix bytes only arm flags; any other byte consumes them.
                            if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                                if (r_ext && r_shift == 8'h75)
                                    r_keys[0] <= !r_brk;
                                if (r_ext && r_shift == 8'h72)
                                    r_keys[1] <= !r_brk;
                                if (!r_ext && r_shift == 8'h5A)
                                    r_keys[2] <= !r_brk;
                                if (!r_ext && r_shift == 8'h76)
                                    r_keys[3] <= !r_brk;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign keyboard_out = r_keys;
    assign scan_code    = r_scan;
    assign frame_valid  = r_valid;
    assign frame_err    = r_err;
endmodule
